// File: rtl/eprisc_io_arbiter.sv
// Two-master round-robin arbiter for the epRISC peripheral register bus.
// Every transaction is IDLE -> ACCESS (single enable cycle) -> DONE (ack), with optional lock.
module eprisc_io_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iReqA,
  input  logic                  iReqB,
  input  logic                  iWriteA,
  input  logic                  iWriteB,
  input  logic [ADDR_WIDTH-1:0] iAddrA,
  input  logic [ADDR_WIDTH-1:0] iAddrB,
  input  logic [DATA_WIDTH-1:0] iDataA,
  input  logic [DATA_WIDTH-1:0] iDataB,
  input  logic                  iLockA,
  input  logic                  iLockB,
  output logic                  oAckA,
  output logic                  oAckB,
  output logic [DATA_WIDTH-1:0] oDataA,
  output logic [DATA_WIDTH-1:0] oDataB,
  output logic [1:0]            oGrant,
  output logic [ADDR_WIDTH-1:0] oAddress,
  output logic [DATA_WIDTH-1:0] oData,
  input  logic [DATA_WIDTH-1:0] iData,
  output logic                  oWrite,
  output logic                  oEnable
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;    // 0 = A, 1 = B
  logic                  last_q, last_d;      // master granted most recently
  logic                  locked_q, locked_d;
  logic [1:0]            grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  enable_q, enable_d;
  logic                  ack_a_q, ack_a_d;
  logic                  ack_b_q, ack_b_d;
  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_WIDTH-1:0] rdata_b_q, rdata_b_d;

  logic start;
  logic win;
  logic own_req;
  logic own_lock;

  assign own_req  = owner_q ? iReqB  : iReqA;
  assign own_lock = owner_q ? iLockB : iLockA;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    locked_d  = locked_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    enable_d  = 1'b0;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    start     = 1'b0;
    win       = owner_q;

    case (state_q)
      IDLE: begin
        if (locked_q) begin
          if (own_req) begin
            start = 1'b1;
            win   = owner_q;
          end else if (!own_lock) begin
            locked_d = 1'b0;
            grant_d  = 2'b00;
          end
        end else if (iReqA && iReqB) begin
          // Contention goes to whoever was not served last.
          start = 1'b1;
          win   = ~last_q;
        end else if (iReqA) begin
          start = 1'b1;
          win   = 1'b0;
        end else if (iReqB) begin
          start = 1'b1;
          win   = 1'b1;
        end

        if (start) begin
          state_d  = ACCESS;
          owner_d  = win;
          last_d   = win;
          grant_d  = win ? 2'b10 : 2'b01;
          addr_d   = win ? iAddrB  : iAddrA;
          wdata_d  = win ? iDataB  : iDataA;
          write_d  = win ? iWriteB : iWriteA;
          enable_d = 1'b1;
        end
      end

      ACCESS: begin
        state_d = DONE;
        if (!write_q) begin
          if (owner_q) rdata_b_d = iData;
          else         rdata_a_d = iData;
        end
        if (owner_q) ack_b_d = 1'b1;
        else         ack_a_d = 1'b1;
      end

      DONE: begin
        state_d  = IDLE;
        locked_d = own_lock;
        if (!own_lock) grant_d = 2'b00;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      locked_q  <= 1'b0;
      grant_q   <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      enable_q  <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      locked_q  <= locked_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      enable_q  <= enable_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign oAckA    = ack_a_q;
  assign oAckB    = ack_b_q;
  assign oDataA   = rdata_a_q;
  assign oDataB   = rdata_b_q;
  assign oGrant   = grant_q;
  assign oAddress = addr_q;
  assign oData    = wdata_q;
  assign oWrite   = write_q;
  assign oEnable  = enable_q;

endmodule
